// File: rtl/dpram_fifo_pkg.sv
// Shared defaults and pointer-width helper for the dual-port RAM FIFO.
// Pointers carry one extra wrap bit above the RAM address.
package dpram_fifo_pkg;

  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_ADDR_WIDTH   = 3;
  localparam int DEF_AFULL_THRESH = 6;

  function automatic int ptr_w(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/dpram_fifo_if.sv
// Producer/consumer bundle for dpram_fifo; master drives requests, slave is the FIFO.
// DPRAM_FIFO_ERR_EN adds the sticky overflow/underflow flags.
interface dpram_fifo_if
  import dpram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   count;
`ifdef DPRAM_FIFO_ERR_EN
  logic                  overflow;
  logic                  underflow;
`endif

  modport master (
    output wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, empty, almost_full, count
`ifdef DPRAM_FIFO_ERR_EN
    , input overflow, underflow
`endif
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty, almost_full, count
`ifdef DPRAM_FIFO_ERR_EN
    , output overflow, underflow
`endif
  );

endinterface

// File: rtl/dpram_fifo_sdp_ram.sv
// Simple dual-port RAM: write port A, registered read port B, 1-cycle read latency.
// Read register clears on reset and holds when not enabled; array contents are never cleared.
module sdp_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/dpram_fifo.sv
// Synchronous FIFO over sdp_ram: 1-cycle write-to-status and read latency; full drops writes, empty drops reads.
// Define DPRAM_FIFO_ERR_EN to expose sticky overflow/underflow flags on the interface.
module dpram_fifo
  import dpram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int AFULL_THRESH = DEF_AFULL_THRESH
) (
  input logic        clk,
  input logic        reset,
  dpram_fifo_if.slave bus
);

  localparam int             PW        = ptr_w(ADDR_WIDTH);
  localparam logic [PW-1:0]  PTR_ONE   = PW'(1);
  localparam logic [PW-1:0]  FULL_XOR  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [PW-1:0]  AFULL_THR = PW'(AFULL_THRESH);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] count_q;
  logic [PW-1:0] count_nxt;
  logic          afull_q;
  logic          rd_valid_q;
  logic          full_w;
  logic          empty_w;
  logic          wr_acc;
  logic          rd_acc;

  // Flags decode registered pointers only, so requests never reach them combinationally.
  assign full_w  = (wr_ptr ^ rd_ptr) == FULL_XOR;
  assign empty_w = (wr_ptr == rd_ptr);
  assign wr_acc  = bus.wr_en && !full_w;
  assign rd_acc  = bus.rd_en && !empty_w;

  always_comb begin
    count_nxt = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count_q + PTR_ONE;
      2'b01:   count_nxt = count_q - PTR_ONE;
      default: count_nxt = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      afull_q    <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      count_q    <= count_nxt;
      afull_q    <= (count_nxt >= AFULL_THR);
      rd_valid_q <= rd_acc;
    end
  end

  sdp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (wr_acc),
    .waddr (wr_ptr[ADDR_WIDTH-1:0]),
    .wdata (bus.wr_data),
    .re    (rd_acc),
    .raddr (rd_ptr[ADDR_WIDTH-1:0]),
    .rdata (bus.rd_data)
  );

  assign bus.rd_valid    = rd_valid_q;
  assign bus.full        = full_w;
  assign bus.empty       = empty_w;
  assign bus.almost_full = afull_q;
  assign bus.count       = count_q;

`ifdef DPRAM_FIFO_ERR_EN
  logic overflow_q;
  logic underflow_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_q  | (bus.wr_en && full_w);
      underflow_q <= underflow_q | (bus.rd_en && empty_w);
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`endif

endmodule
